// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register: owns the PC, drives a
// synchronous-read instruction memory and registers the fetched word for decode.
module fetch_stage #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   flush_D,
  input  logic                   PCSrc,
  input  logic [ADDR_WIDTH-1:0]  PCTarget,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [INSTR_WIDTH-1:0] Instr_D,
  output logic [ADDR_WIDTH-1:0]  PC_D,
  output logic [ADDR_WIDTH-1:0]  PCPlus4_D,
  output logic [2:0]             Opcode_D,
  output logic [2:0]             Funct_D,
  output logic                   Vec_D,
  output logic                   valid_D,
  output logic [31:0]            fetch_count
);

  localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

  logic [ADDR_WIDTH-1:0] pc_F;
  logic [ADDR_WIDTH-1:0] pc_plus4_F;
  logic [ADDR_WIDTH-1:0] pc_next;
  logic                  bubble_D;
  logic                  load_D;

  assign pc_plus4_F = pc_F + PC_STEP;

  always_comb begin
    // NOTE: pc_next gets a default before the priority chain, so every path
    // assigns it and no latch is inferred.
    pc_next = pc_plus4_F;
    if (rst)        pc_next = RESET_PC;
    else if (PCSrc) pc_next = PCTarget & ALIGN_MASK;
    else if (stall) pc_next = pc_F;
  end

  // The memory is addressed with next-PC so its registered output lines up
  // with pc_F; a stall simply re-reads the same word.
  assign imem_addr = pc_next;

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    pc_F <= pc_next;
  end

  // A redirect squashes the wrong-path fall-through word even when stalled.
  assign bubble_D = rst | PCSrc | flush_D;
  assign load_D   = ~bubble_D & ~stall;

  always_ff @(posedge clk) begin
    if (bubble_D) begin
      Instr_D   <= '0;
      PC_D      <= '0;
      PCPlus4_D <= '0;
      valid_D   <= 1'b0;
    end else if (load_D) begin
      Instr_D   <= imem_rdata;
      PC_D      <= pc_F;
      PCPlus4_D <= pc_plus4_F;
      valid_D   <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         fetch_count <= '0;
    else if (load_D) fetch_count <= fetch_count + 32'd1;
  end

  assign Opcode_D = Instr_D[31:29];
  assign Funct_D  = Instr_D[28:26];
  assign Vec_D    = Instr_D[25];

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed test-plan sequence with literal
// expectations, then randomized control inputs checked against a reference model.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush_D;
  logic        PCSrc;
  logic [31:0] PCTarget;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] Instr_D;
  logic [31:0] PC_D;
  logic [31:0] PCPlus4_D;
  logic [2:0]  Opcode_D;
  logic [2:0]  Funct_D;
  logic        Vec_D;
  logic        valid_D;
  logic [31:0] fetch_count;

  int n_vec = 0;
  int n_bad = 0;

  fetch_stage dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .flush_D    (flush_D),
    .PCSrc      (PCSrc),
    .PCTarget   (PCTarget),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .Instr_D    (Instr_D),
    .PC_D       (PC_D),
    .PCPlus4_D  (PCPlus4_D),
    .Opcode_D   (Opcode_D),
    .Funct_D    (Funct_D),
    .Vec_D      (Vec_D),
    .valid_D    (valid_D),
    .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image: a few fixed words at the bottom, a scrambled pattern elsewhere.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h2000_0001;
      32'h4:   return 32'h4400_0002;
      32'h8:   return 32'h6200_0003;
      32'hC:   return 32'h0000_0000;
      default: return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endcase
  endfunction

  always @(posedge clk) imem_rdata <= word_at(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: address being fetched, the decode-stage instruction record
  // and the delivered-instruction count, advanced by the stage's rules per edge.
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pcd;
  logic        m_valid;
  logic [31:0] m_count;
  bit          m_live = 1'b0;

  function automatic logic [31:0] model_next_pc();
    if (rst)   return 32'h0;
    if (PCSrc) return {PCTarget[31:2], 2'b00};
    if (stall) return m_pc;
    return m_pc + 32'd4;
  endfunction

  always @(posedge clk) begin
    if (rst || PCSrc || flush_D) begin
      m_instr = 32'h0;
      m_pcd   = 32'h0;
      m_valid = 1'b0;
    end else if (!stall) begin
      m_instr = word_at(m_pc);
      m_pcd   = m_pc;
      m_valid = 1'b1;
      m_count = m_count + 32'd1;
    end
    if (rst) begin
      m_count = 32'h0;
      m_live  = 1'b1;
    end
    m_pc = model_next_pc();
    #1;
    if (m_live) begin
      check("imem_addr", imem_addr, model_next_pc());
      check("Instr_D", Instr_D, m_instr);
      check("PC_D", PC_D, m_pcd);
      check("PCPlus4_D", PCPlus4_D, m_valid ? m_pcd + 32'd4 : 32'h0);
      check("Opcode_D", {29'h0, Opcode_D}, {29'h0, m_instr[31:29]});
      check("Funct_D", {29'h0, Funct_D}, {29'h0, m_instr[28:26]});
      check("Vec_D", {31'h0, Vec_D}, {31'h0, m_instr[25]});
      check("valid_D", {31'h0, valid_D}, {31'h0, m_valid});
      check("fetch_count", fetch_count, m_count);
    end
  end

  // Apply one cycle of inputs away from the edge, then wait past the model compare.
  task automatic cyc(input logic r, input logic s, input logic f, input logic b,
                     input logic [31:0] tgt);
    @(negedge clk);
    rst = r; stall = s; flush_D = f; PCSrc = b; PCTarget = tgt;
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush_D = 1'b0; PCSrc = 1'b0; PCTarget = '0;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    check("rst valid", {31'h0, valid_D}, 32'h0);
    check("rst count", fetch_count, 32'h0);
    check("rst PC_D", PC_D, 32'h0);
    check("rst imem_addr", imem_addr, 32'h0);

    // Reset release: first word loads at the end of C0.
    cyc(0, 0, 0, 0, 0);
    check("first valid", {31'h0, valid_D}, 32'h1);
    check("first PC_D", PC_D, 32'h0);
    check("first Instr", Instr_D, 32'h2000_0001);
    check("first Opcode", {29'h0, Opcode_D}, 32'h1);
    check("first Funct", {29'h0, Funct_D}, 32'h0);
    check("first Vec", {31'h0, Vec_D}, 32'h0);
    cyc(0, 0, 0, 0, 0);
    check("second PC_D", PC_D, 32'h4);
    check("second Opcode", {29'h0, Opcode_D}, 32'h2);
    check("second Funct", {29'h0, Funct_D}, 32'h1);
    cyc(0, 0, 0, 0, 0);
    check("third PC_D", PC_D, 32'h8);

    // Three-cycle stall while PC_D = 8.
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 0, 0);
      check("stall PC_D", PC_D, 32'h8);
      check("stall Instr", Instr_D, 32'h6200_0003);
      check("stall imem_addr", imem_addr, 32'hC);
      check("stall count", fetch_count, 32'd3);
    end
    cyc(0, 0, 0, 0, 0);
    check("post-stall PC_D", PC_D, 32'hC);
    check("fourth count", fetch_count, 32'd4);

    // Redirect from pc_F = 0x10 to 0x103 (low bits ignored).
    cyc(0, 0, 0, 1, 32'h103);
    check("redir bubble valid", {31'h0, valid_D}, 32'h0);
    check("redir bubble Instr", Instr_D, 32'h0);
    cyc(0, 0, 0, 0, 0);
    check("target PC_D", PC_D, 32'h100);
    check("target PCPlus4", PCPlus4_D, 32'h104);
    check("target count", fetch_count, 32'd5);

    // Redirect together with stall.
    cyc(0, 1, 0, 1, 32'h200);
    check("redir+stall valid", {31'h0, valid_D}, 32'h0);
    cyc(0, 0, 0, 0, 0);
    check("redir+stall PC_D", PC_D, 32'h200);

    // Flush alone: pc_F 0x204 is discarded, fetch continues at 0x208.
    cyc(0, 0, 1, 0, 0);
    check("flush valid", {31'h0, valid_D}, 32'h0);
    cyc(0, 0, 0, 0, 0);
    check("flush PC_D", PC_D, 32'h208);
    check("pre-rst count", fetch_count, 32'd7);

    // One-cycle reset mid-stream.
    cyc(1, 0, 0, 0, 0);
    check("mid-rst valid", {31'h0, valid_D}, 32'h0);
    check("mid-rst count", fetch_count, 32'h0);
    check("mid-rst imem_addr", imem_addr, 32'h0);
    cyc(0, 0, 0, 0, 0);
    check("after-rst PC_D", PC_D, 32'h0);

    // PC wrap.
    cyc(0, 0, 0, 1, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0, 0);
    check("wrap PC_D a", PC_D, 32'hFFFF_FFFC);
    check("wrap PCPlus4 a", PCPlus4_D, 32'h0);
    cyc(0, 0, 0, 0, 0);
    check("wrap PC_D b", PC_D, 32'h0);
    check("wrap PCPlus4 b", PCPlus4_D, 32'h4);

    // Randomized control traffic, checked every cycle by the model compare.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                        : $urandom;
      cyc($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 25,
          $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 8, tgt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the processor. It holds the PC, drives the synchronous-read instruction memory, and registers the fetched word. It splits the word into the Opcode/Funct/Vec fields consumed by `control_unit` in decode. It also handles stall, flush and branch-redirect requests, and keeps a count of the instructions it delivers.

## Interface
Parameters:
- `ADDR_WIDTH`, default 32: PC and instruction-memory address width; byte addressing.
- `INSTR_WIDTH`, default 32: instruction width.
- `RESET_PC`, default 0: PC value after reset; must be a multiple of 4.

Ports:
- `clk`, in, 1: the single clock; every register updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `stall`, in, 1: hold the PC and the IF/ID register.
- `flush_D`, in, 1: load a bubble into IF/ID.
- `PCSrc`, in, 1: redirect fetch to `PCTarget`.
- `PCTarget`, in, ADDR_WIDTH: redirect address; bits [1:0] are ignored and treated as 00.
- `imem_addr`, out, ADDR_WIDTH: instruction-memory read address; memory data returns one cycle later.
- `imem_rdata`, in, INSTR_WIDTH: word at the `imem_addr` presented in the previous cycle.
- `Instr_D`, out, INSTR_WIDTH: registered instruction.
- `PC_D`, out, ADDR_WIDTH: PC of `Instr_D`.
- `PCPlus4_D`, out, ADDR_WIDTH: `PC_D + 4`, modulo 2^ADDR_WIDTH.
- `Opcode_D`, out, 3: `Instr_D[31:29]`.
- `Funct_D`, out, 3: `Instr_D[28:26]`.
- `Vec_D`, out, 1: `Instr_D[25]`.
- `valid_D`, out, 1: `Instr_D` holds a real instruction, not a bubble.
- `fetch_count`, out, 32: number of valid instructions loaded into IF/ID.

## Operation
- Internal state:
  - `pc_F`: address of the word currently on `imem_rdata`.
  - The IF/ID register: `Instr_D`, `PC_D`, `PCPlus4_D`, `valid_D`.
  - `fetch_count`.
- Next PC and `imem_addr` are combinational: `pc_next` = `RESET_PC` if `rst`; else `{PCTarget[AW-1:2],2'b00}` if `PCSrc`; else `pc_F` if `stall`; else `pc_F + 4`, wrapping modulo 2^ADDR_WIDTH.
- `imem_addr = pc_next`. Every edge: `pc_F <= pc_next`. Consequence: `imem_rdata` always corresponds to `pc_F`, including under stall, because the same address is re-read.
- IF/ID update, priority high to low:
  1. `rst`: bubble.
  2. `PCSrc` or `flush_D`: bubble. Under `PCSrc` the squashed word is the wrong-path fall-through.
  3. `stall`: hold all fields.
  4. Otherwise: load `Instr_D <= imem_rdata`, `PC_D <= pc_F`, `PCPlus4_D <= pc_F + 4`, `valid_D <= 1`.
- Bubble contents: `Instr_D = 0` (Opcode 000, decoded as NOP), `PC_D = 0`, `PCPlus4_D = 0`, `valid_D = 0`.
- `PCSrc` overrides `stall` for the PC. Simultaneous `PCSrc` and `stall`: redirect happens and IF/ID takes a bubble.
- `fetch_count` increments by 1, wrapping at 2^32, exactly on edges where rule 4 loads IF/ID. It holds on stall and bubble edges and resets to 0.
- Opcode_D, Funct_D and Vec_D are pure wiring from `Instr_D`. With INSTR_WIDTH=32, field positions are fixed as listed in Interface.

## Timing
- Reset values:
  - `pc_F = RESET_PC`.
  - `imem_addr = RESET_PC` while `rst` is high.
  - IF/ID outputs all 0; `valid_D = 0`.
  - `fetch_count = 0`.
- Cycle after `rst` falls (call it C0): `imem_rdata` = mem[RESET_PC], `imem_addr = RESET_PC+4`. The edge at the end of C0 loads mem[RESET_PC] into IF/ID. Reset-to-first-valid-`valid_D` latency is therefore 1 cycle after reset release.
- Sequential fetch: one instruction per cycle. `PC_D` advances by 4 per cycle.
- Redirect: `PCSrc` high in cycle t.
  - End of t: IF/ID takes a bubble.
  - Cycle t+1: `imem_rdata` = mem[target], `valid_D = 0`.
  - End of t+1: target instruction enters IF/ID.
  - Penalty: 1 bubble from this stage.
- Stall over N cycles: outputs are frozen for N cycles, and `imem_addr` is constant (= `pc_F`). On the first unstalled edge the held word is loaded with no loss and no duplication.
- `flush_D` without `PCSrc`: the PC still advances unless `stall` is asserted. The word in F is discarded, not replayed.
- `rst` mid-stall or mid-redirect: reset wins on that edge and all state returns to reset values.
- PC wrap: `pc_F = 2^ADDR_WIDTH - 4` is followed by `pc_F = 0`, with no flag raised.

## Test plan
- Reset release with RESET_PC=0 and mem[0..3]=0x20000001, 0x44000002, 0x62000003, 0x00000000 → `valid_D` is 1 from the second cycle after release. `PC_D` shows 0, 4, 8, 12. For the first word, `Opcode_D=001`, `Funct_D=000`, `Vec_D=0`. `fetch_count` reaches 4 after the 4th load.
- `stall` for 3 cycles while `PC_D=8` → all outputs hold, `imem_addr` stays 12, `fetch_count` holds. The next `PC_D` is 12, with no skip and no repeat.
- `PCSrc=1` with `PCTarget=0x103` while `pc_F=0x10` → the next IF/ID is a bubble (`Instr_D=0`, `valid_D=0`). The following `PC_D` is 0x100 and `PCPlus4_D` is 0x104.
- `PCSrc` and `stall` asserted together → redirect still taken and a bubble is loaded. `flush_D` alone → one bubble, and the PC advances by 4.
- `rst` asserted for one cycle mid-stream with `fetch_count=7` → the next cycle shows `pc_F=RESET_PC`, `valid_D=0`, `fetch_count=0`.
- PC wrap: redirect to 0xFFFFFFFC with no stalls → `PC_D` shows 0xFFFFFFFC then 0x00000000. `PCPlus4_D` shows 0x00000000 then 0x00000004.
